// File: rtl/spi_bytes_to_packets.sv
// spi_bytes_to_packets: decodes the SPI PHY byte stream into Avalon-ST packets.
// Optional macro SPI_B2P_PKT_ERR_EN adds SOP/EOP framing checks on pkt_err.
module spi_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     pkt_err,
    input  logic                     err_clr
);
    localparam logic [7:0] SOP = 8'h7A;
    localparam logic [7:0] EOP = 8'h7B;
    localparam logic [7:0] CHN = 8'h7C;
    localparam logic [7:0] ESC = 8'h7D;

    logic                     r_sop_pend;
    logic                     r_eop_pend;
    logic                     r_chan_pend;
    logic                     r_esc_pend;
    logic [CHANNEL_WIDTH-1:0] r_chan;
    logic                     w_accept;
    logic                     w_ctrl;
    logic                     w_emit;
    logic [7:0]               w_lit;

    // Single output register without skid: take a byte only when the slot is free or draining.
    assign in_ready = ~out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    // An escaped byte is never a control byte, whatever its value.
    assign w_ctrl   = ~r_esc_pend & (in_data >= SOP) & (in_data <= ESC);
    assign w_lit    = r_esc_pend ? in_data ^ 8'h20 : in_data;
    assign w_emit   = w_accept & ~w_ctrl & ~r_chan_pend;

    // Control-byte decoding, channel loading and the output register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sop_pend        <= 1'b0;
            r_eop_pend        <= 1'b0;
            r_chan_pend       <= 1'b0;
            r_esc_pend        <= 1'b0;
            r_chan            <= '0;
            out_data          <= 8'h00;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (w_accept) begin
                r_esc_pend <= w_ctrl & (in_data == ESC);
                if (w_ctrl) begin
                    if (in_data == SOP) r_sop_pend  <= 1'b1;
                    if (in_data == EOP) r_eop_pend  <= 1'b1;
                    if (in_data == CHN) r_chan_pend <= 1'b1;
                end else if (r_chan_pend) begin
                    r_chan      <= w_lit[CHANNEL_WIDTH-1:0];
                    r_chan_pend <= 1'b0;
                end else begin
                    out_data          <= w_lit;
                    out_valid         <= 1'b1;
                    out_startofpacket <= r_sop_pend;
                    out_endofpacket   <= r_eop_pend;
                    out_channel       <= r_chan;
                    r_sop_pend        <= 1'b0;
                    r_eop_pend        <= 1'b0;
                end
            end
        end
    end

`ifdef SPI_B2P_PKT_ERR_EN
    logic r_in_packet;
    logic w_err;

    // Data outside a packet, or a new SOP inside one, is a framing error.
    assign w_err = w_emit & (r_sop_pend ? r_in_packet : ~r_in_packet);

    // Packet tracking and the sticky error flag; a fresh error beats err_clr.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_in_packet <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            if (w_emit)
                r_in_packet <= (r_in_packet | r_sop_pend) & ~r_eop_pend;
            if (w_err)
                pkt_err <= 1'b1;
            else if (err_clr)
                pkt_err <= 1'b0;
        end
    end
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign pkt_err          = 1'b0;
`endif
endmodule

// File: tb/tb_spi_bytes_to_packets.sv
// tb_spi_bytes_to_packets: directed and randomised checks of the SPI byte-to-packet decoder.
module tb_spi_bytes_to_packets;
    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_startofpacket;
    logic       out_endofpacket;
    logic [7:0] out_channel;
    logic       pkt_err;
    logic       err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] obs_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  stim_q[$];
    bit done;

    spi_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
        .sysclk(sysclk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_channel(out_channel), .pkt_err(pkt_err), .err_clr(err_clr)
    );

    always #5 sysclk = ~sysclk;

    // Record every output handshake, sampled well after the falling-edge drives.
    always @(negedge sysclk) begin
        #2;
        if (out_valid && out_ready)
            obs_q.push_back({out_channel, out_startofpacket, out_endofpacket, out_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pk(input logic [7:0] ch, input logic s, input logic e, input logic [7:0] d);
        return {ch, s, e, d};
    endfunction

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge sysclk);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge sysclk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset    = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(negedge sysclk);
        reset = 1'b0;
        #3;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic enc(input logic [7:0] b);
        if (b >= 8'h7A && b <= 8'h7D) begin
            stim_q.push_back(8'h7D);
            stim_q.push_back(b ^ 8'h20);
        end else
            stim_q.push_back(b);
    endtask

    initial begin
        logic [7:0] ch;
        logic [7:0] d;
        int len;
        // Reset state
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sop", out_startofpacket, 0);
        check("rst_eop", out_endofpacket, 0);
        check("rst_chan", out_channel, 0);
        check("rst_ready", in_ready, 1);
        check("rst_err", pkt_err, 0);

        // Basic packet, one-cycle latency
        send(8'h7A);
        check("t1_ctrl_noout", out_valid, 0);
        send(8'h11);
        check("t1_lat_valid", out_valid, 1);
        check("t1_lat_data", out_data, 8'h11);
        check("t1_lat_sop", out_startofpacket, 1);
        send(8'h22);
        send(8'h7B);
        send(8'h33);
        repeat (3) @(negedge sysclk);
        exp_q = '{pk(0, 1, 0, 8'h11), pk(0, 0, 0, 8'h22), pk(0, 0, 1, 8'h33)};
        cmp_q("t1");

        // Channel byte, escapes, channel persistence
        do_reset();
        foreach (stim_q[i]) stim_q.delete();
        stim_q = '{8'h7C, 8'h05, 8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D, 8'h7A, 8'h66, 8'h7B, 8'h67};
        foreach (stim_q[i]) send(stim_q[i]);
        stim_q.delete();
        repeat (3) @(negedge sysclk);
        exp_q = '{pk(5, 1, 0, 8'h7A), pk(5, 0, 1, 8'h7D), pk(5, 1, 0, 8'h66), pk(5, 0, 1, 8'h67)};
        cmp_q("t2");

        // Backpressure hold
        do_reset();
        send(8'h7A);
        send(8'h01);
        out_ready = 1'b0;
        @(negedge sysclk);
        in_data  = 8'h02;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_in_ready", in_ready, 0);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_data", out_data, 8'h01);
            check("t3_hold_sop", out_startofpacket, 1);
            @(negedge sysclk);
        end
        out_ready = 1'b1;
        @(posedge sysclk);
        #1 in_valid = 1'b0;
        send(8'h7B);
        send(8'h03);
        repeat (3) @(negedge sysclk);
        exp_q = '{pk(0, 1, 0, 8'h01), pk(0, 0, 0, 8'h02), pk(0, 0, 1, 8'h03)};
        cmp_q("t3");

        // Reset mid-packet
        do_reset();
        send(8'h7C);
        send(8'h03);
        send(8'h7A);
        send(8'h11);
        reset = 1'b1;
        #1;
        check("t4_valid", out_valid, 0);
        check("t4_data", out_data, 0);
        check("t4_sop", out_startofpacket, 0);
        check("t4_chan", out_channel, 0);
        check("t4_err", pkt_err, 0);
        @(negedge sysclk);
        reset = 1'b0;
        obs_q.delete();
        send(8'h44);
        check("t4_post_valid", out_valid, 1);
        check("t4_post_data", out_data, 8'h44);
        check("t4_post_sop", out_startofpacket, 0);
        check("t4_post_chan", out_channel, 0);

        // Framing error flag
        do_reset();
        send(8'h7A);
        send(8'h01);
        check("t5_err_first", pkt_err, 0);
        send(8'h7A);
        send(8'h02);
`ifdef SPI_B2P_PKT_ERR_EN
        check("t5_err_dup_sop", pkt_err, 1);
`else
        check("t5_err_dup_sop", pkt_err, 0);
`endif
        @(negedge sysclk);
        err_clr = 1'b1;
        @(posedge sysclk);
        #1 err_clr = 1'b0;
        check("t5_err_clr", pkt_err, 0);
        send(8'h7B);
        send(8'h03);
        check("t5_err_eop", pkt_err, 0);
        send(8'h7A);
        send(8'h7B);
        send(8'h0A);
        check("t5_err_single", pkt_err, 0);
        send(8'h09);
`ifdef SPI_B2P_PKT_ERR_EN
        check("t5_err_outside", pkt_err, 1);
`else
        check("t5_err_outside", pkt_err, 0);
`endif

        // Random traffic against an encoder-side reference
        do_reset();
        ch = 8'h00;
        for (int p = 0; p < 400; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = ($urandom_range(0, 3) == 0) ? 8'h7A + 8'($urandom_range(0, 3)) : 8'($urandom);
                stim_q.push_back(8'h7C);
                enc(ch);
            end
            stim_q.push_back(8'h7A);
            if ($urandom_range(0, 4) == 0) stim_q.push_back(8'h7A);
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                d = ($urandom_range(0, 3) == 0) ? 8'h7A + 8'($urandom_range(0, 3)) : 8'($urandom);
                if (k == len - 1) stim_q.push_back(8'h7B);
                enc(d);
                exp_q.push_back(pk(ch, k == 0, k == len - 1, d));
            end
        end
        done = 1'b0;
        fork
            begin
                foreach (stim_q[i]) begin
                    repeat ($urandom_range(0, 2)) @(negedge sysclk);
                    send(stim_q[i]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge sysclk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(negedge sysclk);
        cmp_q("t6");
        check("t6_err", pkt_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
